// File: rtl/instr_rom_loadable.sv
// Loadable instruction ROM: registered one-cycle fetch plus a streaming
// program-load port with per-word valid tracking.
module instr_rom_loadable #(
    parameter int                    DATA_WIDTH   = 28,
    parameter int                    ADDR_WIDTH   = 16,
    parameter int                    DEPTH        = 256,
    parameter logic [DATA_WIDTH-1:0] DEFAULT_WORD = 'h00000AA
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [ADDR_WIDTH-1:0] iAddress,
    input  logic                  iReadEnable,
    output logic [DATA_WIDTH-1:0] oInstruction,
    output logic                  oValid,
    input  logic                  iLoadStart,
    input  logic [ADDR_WIDTH-1:0] iLoadBase,
    input  logic [DATA_WIDTH-1:0] iLoadData,
    input  logic                  iLoadValid,
    input  logic                  iLoadLast,
    output logic                  oLoadReady,
    output logic                  oLoadDone,
    output logic                  oLoadError,
    output logic [ADDR_WIDTH:0]   oLoadCount,
    output logic                  oBusy
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] LAST_L  = DEPTH_L - {{ADDR_WIDTH{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
    logic [ADDR_WIDTH:0]     cnt_q, cnt_d;
    logic [DEPTH-1:0]        wvalid_q, wvalid_d;
    logic                    ready_q, ready_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;
    logic                    busy_q, busy_d;
    logic [DATA_WIDTH-1:0]   instr_q, instr_d;
    logic                    rvalid_q, rvalid_d;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic [IDX_W-1:0]        ptr_idx;
    logic [IDX_W-1:0]        addr_idx;
    logic                    accept;
    logic                    base_ok;
    logic                    addr_ok;
    logic                    at_end;

    assign ptr_idx  = ptr_q[IDX_W-1:0];
    assign addr_idx = iAddress[IDX_W-1:0];
    assign accept   = ready_q & iLoadValid;
    assign base_ok  = {1'b0, iLoadBase} < DEPTH_L;
    assign addr_ok  = {1'b0, iAddress} < DEPTH_L;
    assign at_end   = {1'b0, ptr_q} == LAST_L;

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        wvalid_d = wvalid_q;
        err_d    = 1'b0;
        instr_d  = instr_q;
        rvalid_d = 1'b0;

        case (state_q)
            RUN: begin
                if (iLoadStart) begin
                    if (base_ok) begin
                        state_d = LOAD;
                        ptr_d   = iLoadBase;
                        cnt_d   = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (accept) begin
                    wvalid_d[ptr_idx] = 1'b1;
                    ptr_d = ptr_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                    cnt_d = cnt_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
                    // Stop at the top of storage; the pointer never wraps.
                    if (iLoadLast || at_end) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase

        ready_d = (state_d == LOAD);
        busy_d  = (state_d != RUN);
        done_d  = (state_d == DONE);

        if (iReadEnable) begin
            if (state_q == RUN) begin
                rvalid_d = 1'b1;
                if (addr_ok && wvalid_q[addr_idx]) begin
                    instr_d = mem[addr_idx];
                end else begin
                    instr_d = DEFAULT_WORD;
                end
            end else begin
                instr_d = DEFAULT_WORD;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q  <= RUN;
            ptr_q    <= '0;
            cnt_q    <= '0;
            wvalid_q <= '0;
            ready_q  <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            instr_q  <= DEFAULT_WORD;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            wvalid_q <= wvalid_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            instr_q  <= instr_d;
            rvalid_q <= rvalid_d;
        end
    end

    // Storage itself is never reset; the valid bits gate what is visible.
    always_ff @(posedge Clock) begin
        if (!Reset && accept) begin
            mem[ptr_idx] <= iLoadData;
        end
    end

    assign oInstruction = instr_q;
    assign oValid       = rvalid_q;
    assign oLoadReady   = ready_q;
    assign oLoadDone    = done_q;
    assign oLoadError   = err_q;
    assign oLoadCount   = cnt_q;
    assign oBusy        = busy_q;

endmodule

// File: tb/tb_instr_rom_loadable.sv
// Directed bench for instr_rom_loadable with a read scoreboard
// and a reference model of storage and valid bits.
module tb_instr_rom_loadable;

    localparam int DW = 28;
    localparam int AW = 16;
    localparam int DEPTH = 256;
    localparam logic [DW-1:0] DEF = 28'h00000AA;

    typedef struct packed {
        logic          v;
        logic [DW-1:0] d;
    } rd_t;

    logic          Clock = 1'b0;
    logic          Reset = 1'b1;
    logic [AW-1:0] iAddress = '0;
    logic          iReadEnable = 1'b0;
    logic [DW-1:0] oInstruction;
    logic          oValid;
    logic          iLoadStart = 1'b0;
    logic [AW-1:0] iLoadBase = '0;
    logic [DW-1:0] iLoadData = '0;
    logic          iLoadValid = 1'b0;
    logic          iLoadLast = 1'b0;
    logic          oLoadReady;
    logic          oLoadDone;
    logic          oLoadError;
    logic [AW:0]   oLoadCount;
    logic          oBusy;

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] mdl [DEPTH];
    bit            mv  [DEPTH];
    rd_t           sb [$];

    instr_rom_loadable dut (
        .Clock(Clock), .Reset(Reset),
        .iAddress(iAddress), .iReadEnable(iReadEnable),
        .oInstruction(oInstruction), .oValid(oValid),
        .iLoadStart(iLoadStart), .iLoadBase(iLoadBase),
        .iLoadData(iLoadData), .iLoadValid(iLoadValid),
        .iLoadLast(iLoadLast), .oLoadReady(oLoadReady),
        .oLoadDone(oLoadDone), .oLoadError(oLoadError),
        .oLoadCount(oLoadCount), .oBusy(oBusy)
    );

    always #5 Clock = ~Clock;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] exp_word(input int a);
        if (a < DEPTH && mv[a]) return mdl[a];
        return DEF;
    endfunction

    task automatic sb_check(input string tag);
        rd_t e;
        tests++;
        if (sb.size() == 0) begin
            fails++;
            $error("FAIL %s: observed empty scoreboard expected entry", tag);
        end else begin
            e = sb.pop_front();
            tests--;
            check({tag, ".v"}, 64'(oValid), 64'(e.v));
            check({tag, ".d"}, 64'(oInstruction), 64'(e.d));
        end
    endtask

    task automatic do_read(input int a, input string tag);
        @(negedge Clock);
        iAddress = AW'(a);
        iReadEnable = 1'b1;
        sb.push_back('{v: 1'b1, d: exp_word(a)});
        @(posedge Clock);
        #1;
        iReadEnable = 1'b0;
        sb_check(tag);
    endtask

    task automatic do_start(input int base);
        @(negedge Clock);
        iLoadStart = 1'b1;
        iLoadBase = AW'(base);
        @(posedge Clock);
        #1;
        iLoadStart = 1'b0;
    endtask

    task automatic send_word(input int a, input logic [DW-1:0] d,
                             input logic last, output logic acc);
        @(negedge Clock);
        iLoadValid = 1'b1;
        iLoadData = d;
        iLoadLast = last;
        acc = oLoadReady;
        @(posedge Clock);
        #1;
        iLoadValid = 1'b0;
        iLoadLast = 1'b0;
        if (acc && a < DEPTH) begin
            mdl[a] = d;
            mv[a] = 1'b1;
        end
    endtask

    initial begin
        logic acc;
        for (int i = 0; i < DEPTH; i++) mv[i] = 1'b0;

        repeat (2) @(posedge Clock);
        #1;
        check("rst.instr", 64'(oInstruction), 64'(DEF));
        check("rst.valid", 64'(oValid), 64'd0);
        check("rst.ready", 64'(oLoadReady), 64'd0);
        check("rst.done", 64'(oLoadDone), 64'd0);
        check("rst.err", 64'(oLoadError), 64'd0);
        check("rst.busy", 64'(oBusy), 64'd0);
        check("rst.count", 64'(oLoadCount), 64'd0);
        @(negedge Clock);
        Reset = 1'b0;

        do_read(0, "t1.rd0");
        do_read(5, "t1.rd5");
        do_read(300, "t1.rd300");
        @(posedge Clock);
        #1;
        check("t1.idle.valid", 64'(oValid), 64'd0);
        check("t1.idle.hold", 64'(oInstruction), 64'(DEF));

        do_start(0);
        check("t2.ready", 64'(oLoadReady), 64'd1);
        check("t2.busy", 64'(oBusy), 64'd1);
        check("t2.count0", 64'(oLoadCount), 64'd0);
        send_word(0, 28'h1000FF, 1'b0, acc);
        check("t2.acc0", 64'(acc), 64'd1);
        send_word(1, 28'h1030002, 1'b0, acc);
        check("t2.acc1", 64'(acc), 64'd1);
        check("t2.nodone", 64'(oLoadDone), 64'd0);
        send_word(2, 28'h1040004, 1'b1, acc);
        check("t2.acc2", 64'(acc), 64'd1);
        check("t2.done", 64'(oLoadDone), 64'd1);
        check("t2.readyoff", 64'(oLoadReady), 64'd0);
        check("t2.count", 64'(oLoadCount), 64'd3);
        @(posedge Clock);
        #1;
        check("t2.donepulse", 64'(oLoadDone), 64'd0);
        check("t2.idle", 64'(oBusy), 64'd0);
        for (int a = 0; a < 4; a++) do_read(a, $sformatf("t2.rd%0d", a));

        do_start(254);
        for (int k = 0; k < 4; k++) begin
            send_word(254 + k, DW'(28'h2000000 + k), 1'b0, acc);
            check($sformatf("t3.acc%0d", k), 64'(acc), (k < 2) ? 64'd1 : 64'd0);
            if (k == 1) begin
                check("t3.readyoff", 64'(oLoadReady), 64'd0);
                check("t3.done", 64'(oLoadDone), 64'd1);
            end
        end
        check("t3.count", 64'(oLoadCount), 64'd2);
        do_read(254, "t3.rd254");
        do_read(255, "t3.rd255");
        do_read(0, "t3.nowrap");

        do_start(256);
        check("t4.err", 64'(oLoadError), 64'd1);
        check("t4.busy", 64'(oBusy), 64'd0);
        check("t4.ready", 64'(oLoadReady), 64'd0);
        @(posedge Clock);
        #1;
        check("t4.errpulse", 64'(oLoadError), 64'd0);
        check("t4.count", 64'(oLoadCount), 64'd2);
        do_read(1, "t4.run");

        @(negedge Clock);
        iAddress = AW'(10);
        iReadEnable = 1'b1;
        iLoadStart = 1'b1;
        iLoadBase = AW'(10);
        sb.push_back('{v: 1'b1, d: exp_word(10)});
        @(posedge Clock);
        #1;
        iLoadStart = 1'b0;
        sb_check("t5.startrd");
        sb.push_back('{v: 1'b0, d: DEF});
        send_word(10, 28'h0ABCDEF, 1'b0, acc);
        sb_check("t5.blk0");
        check("t5.busy0", 64'(oBusy), 64'd1);
        sb.push_back('{v: 1'b0, d: DEF});
        send_word(11, 28'h0123456, 1'b1, acc);
        sb_check("t5.blk1");
        check("t5.done", 64'(oLoadDone), 64'd1);
        sb.push_back('{v: 1'b0, d: DEF});
        @(posedge Clock);
        #1;
        sb_check("t5.blkdone");
        check("t5.busyoff", 64'(oBusy), 64'd0);
        sb.push_back('{v: 1'b1, d: exp_word(10)});
        @(posedge Clock);
        #1;
        iReadEnable = 1'b0;
        sb_check("t5.first");

        do_start(20);
        send_word(20, 28'h0555555, 1'b0, acc);
        send_word(21, 28'h0666666, 1'b0, acc);
        check("t6.count2", 64'(oLoadCount), 64'd2);
        @(negedge Clock);
        Reset = 1'b1;
        @(posedge Clock);
        #1;
        for (int i = 0; i < DEPTH; i++) mv[i] = 1'b0;
        check("t6.rst.done", 64'(oLoadDone), 64'd0);
        check("t6.rst.busy", 64'(oBusy), 64'd0);
        check("t6.rst.ready", 64'(oLoadReady), 64'd0);
        @(negedge Clock);
        Reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge Clock);
            #1;
            check($sformatf("t6.nodone%0d", k), 64'(oLoadDone), 64'd0);
        end
        do_read(20, "t6.rd20");
        do_read(21, "t6.rd21");
        do_read(0, "t6.rd0");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/instr_rom_loadable.md
Name: instr_rom_loadable

Overview:
Parametrised successor to the fixed case-statement instruction ROM that feeds the MiniAlu fetch stage. Holds DEPTH instruction words of DATA_WIDTH bits and serves them with a registered, one-cycle read. It adds a streaming program-load port, so a program is written at run time without resynthesis. Per-word valid tracking returns a default instruction for unwritten or out-of-range addresses.

Parameters:
DATA_WIDTH, 28, instruction word width.
ADDR_WIDTH, 16, width of the iAddress and iLoadBase ports.
DEPTH, 256, number of storage words; must be ≤ 2^ADDR_WIDTH.
DEFAULT_WORD, 28'h00000AA, word returned for unwritten, out-of-range or blocked reads (LED opcode field plus 8'b10101010 payload).

Ports:
Clock  in  1  system clock; all logic on rising edge.
Reset  in  1  synchronous, active-high reset.
iAddress  in  ADDR_WIDTH  fetch address.
iReadEnable  in  1  fetch request.
oInstruction  out  DATA_WIDTH  registered instruction.
oValid  out  1  oInstruction holds the result of a read accepted in the previous cycle.
iLoadStart  in  1  one-cycle pulse that begins a load session.
iLoadBase  in  ADDR_WIDTH  first write address, sampled with iLoadStart.
iLoadData  in  DATA_WIDTH  word to write.
iLoadValid  in  1  iLoadData is valid.
iLoadLast  in  1  marks the final word of the session.
oLoadReady  out  1  block accepts load words.
oLoadDone  out  1  one-cycle pulse when the session ends.
oLoadError  out  1  one-cycle pulse when iLoadStart is rejected.
oLoadCount  out  ADDR_WIDTH+1  words written in the current or last session.
oBusy  out  1  high in any state other than RUN.

Behaviour:
- Reset values: oInstruction=DEFAULT_WORD; oValid, oLoadReady, oLoadDone, oLoadError, oBusy all 0; oLoadCount=0; FSM=RUN; all DEPTH word-valid bits cleared. Storage array contents are not reset.
- FSM states: RUN, LOAD, DONE.
- RUN to LOAD: iLoadStart=1 and iLoadBase<DEPTH. Write pointer=iLoadBase, oLoadCount=0.
- Rejected start: if iLoadStart=1 and iLoadBase≥DEPTH, stay in RUN and pulse oLoadError for 1 cycle.
- LOAD: oLoadReady=1 and oBusy=1. A word is accepted when iLoadValid & oLoadReady:
  - mem[ptr]=iLoadData, valid[ptr]=1;
  - ptr increments;
  - oLoadCount increments.
- LOAD to DONE: an accepted word has iLoadLast=1, or the accepted word was written to address DEPTH-1. The pointer never wraps. oLoadReady drops in the cycle after that acceptance.
- DONE: lasts exactly 1 cycle. oLoadDone=1, oBusy=1, then return to RUN. oLoadCount holds its value until the next accepted start.
- iLoadStart while in LOAD or DONE is ignored, with no error pulse.
- Read, 1-cycle latency: if iReadEnable is sampled high at edge N, oInstruction and oValid update at edge N+1.
  - In RUN: oInstruction = mem[iAddress] if iAddress<DEPTH and valid[iAddress], else DEFAULT_WORD; oValid=1.
  - In LOAD or DONE: the read is blocked; oInstruction=DEFAULT_WORD, oValid=0.
  - If iReadEnable=0, oValid=0 and oInstruction holds its previous value.
- Same-edge write and read to one address cannot occur, because reads are blocked during a load.
- Reset mid-load: FSM returns to RUN and all valid bits clear, so the whole program is discarded. A partial load is never reported done.
- Loads overwrite: words outside the session's written range keep their previous contents and valid bits.

Test Plan:
1. Reset, then read addresses 0, 5 and 300 in RUN → oInstruction=28'h00000AA with oValid=1 one cycle after each request.
2. Start with iLoadBase=0, then stream 3 words 28'h1000FF, 28'h1030002, 28'h1040004 with iLoadLast on the third → oLoadDone pulses on the cycle after the third acceptance, oLoadCount=3. Reads of addresses 0–2 then return those words; a read of address 3 returns DEFAULT_WORD.
3. Start with iLoadBase=254 and stream 4 words with no iLoadLast → only addresses 254 and 255 are written, oLoadReady drops after the 2nd word, oLoadCount=2, and there is no wrap to address 0.
4. iLoadStart with iLoadBase=256 → oLoadError pulses once, the FSM stays in RUN and oBusy stays 0.
5. iReadEnable held high during a load → oValid=0 and oInstruction=DEFAULT_WORD while oBusy=1. The first read after DONE returns the loaded data.
6. Assert Reset after 2 of 5 words have been accepted → no oLoadDone pulse, and subsequent reads of those 2 addresses return DEFAULT_WORD.
